// File: rtl/tcdm_prio_ctrl.sv
// tcdm_prio_ctrl: anti-starvation priority source for the TCDM arbiters.
// In normal operation (RAND) the arbiters see a pseudo-random priority
// taken from a 16-bit Galois LFSR. If any requester has waited
// StarveThresh cycles in a row, the block switches to LOCK and points the
// arbiters at that requester until it is granted or stops requesting.
// Optional feature: define TCDM_PRIO_CTRL_STATS_EN to add lock_cnt_o, a
// wrapping 16-bit count of RAND->LOCK transitions.
module tcdm_prio_ctrl #(
    parameter int unsigned NumIn        = 4,
    parameter int unsigned PrioWidth    = 4,
    parameter int unsigned StarveThresh = 15,
    parameter logic [15:0] LfsrSeed     = 16'h0001
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumIn-1:0]         req_i,
    input  logic [NumIn-1:0]         gnt_i,
    input  logic                     adv_i,
    output logic [PrioWidth-1:0]     rr_o,
    output logic                     lock_o,
`ifdef TCDM_PRIO_CTRL_STATS_EN
    output logic [15:0]              lock_cnt_o,
`endif
    output logic [$clog2(NumIn)-1:0] lock_idx_o
);

    localparam int unsigned IdxW = $clog2(NumIn);
    localparam int unsigned CntW = $clog2(StarveThresh + 1);
    localparam logic [CntW-1:0] Thresh = CntW'(StarveThresh);
    localparam logic [15:0] LfsrMask = 16'hB400;

    typedef enum logic [0:0] {
        RAND = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
    logic [CntW-1:0]   wcnt_q [NumIn];
    logic [CntW-1:0]   wcnt_d [NumIn];
    logic [NumIn-1:0]  starved;
    logic              any_starved;
    logic [IdxW-1:0]   low_idx;

    // Wait counters: count consecutive ungranted request cycles, saturating.
    always_comb begin
        for (int k = 0; k < NumIn; k++) begin
            wcnt_d[k] = '0;
            if (req_i[k] && !gnt_i[k]) begin
                wcnt_d[k] = (wcnt_q[k] == Thresh) ? Thresh : wcnt_q[k] + 1'b1;
            end
            starved[k] = (wcnt_q[k] == Thresh);
        end
    end

    // Lowest-index starved requester (loop runs high to low so low wins).
    always_comb begin
        low_idx     = '0;
        any_starved = 1'b0;
        for (int k = NumIn - 1; k >= 0; k--) begin
            if (starved[k]) begin
                low_idx     = IdxW'(k);
                any_starved = 1'b1;
            end
        end
    end

    // Next state, lock index and LFSR advance.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        lfsr_d     = lfsr_q;
        unique case (state_q)
            RAND: begin
                if (adv_i) begin
                    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
                end
                if (any_starved) begin
                    state_d    = LOCK;
                    lock_idx_d = low_idx;
                end
            end
            LOCK: begin
                // Index cleared on exit so lock_idx_o reads 0 in RAND.
                if (gnt_i[lock_idx_q] || !req_i[lock_idx_q]) begin
                    state_d    = RAND;
                    lock_idx_d = '0;
                end
            end
            default: state_d = RAND;
        endcase
    end

    // State, LFSR, lock index and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RAND;
            lfsr_q     <= LfsrSeed;
            lock_idx_q <= '0;
            for (int k = 0; k < NumIn; k++) wcnt_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            lock_idx_q <= lock_idx_d;
            for (int k = 0; k < NumIn; k++) wcnt_q[k] <= wcnt_d[k];
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        lock_o     = (state_q == LOCK);
        lock_idx_o = lock_idx_q;
        rr_o       = lock_o ? PrioWidth'(lock_idx_q) : lfsr_q[PrioWidth-1:0];
    end

`ifdef TCDM_PRIO_CTRL_STATS_EN
    logic [15:0] lock_cnt_q, lock_cnt_d;

    // Count lock entries; natural 16-bit wrap.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (state_q == RAND && state_d == LOCK) lock_cnt_d = lock_cnt_q + 16'd1;
    end

    // Lock counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lock_cnt_q <= 16'h0000;
        else       lock_cnt_q <= lock_cnt_d;
    end

    assign lock_cnt_o = lock_cnt_q;
`endif

endmodule

// File: doc/tcdm_prio_ctrl.md
TCDM_PRIO_CTRL -- requirements
Module: tcdm_prio_ctrl

Interface
REQ-001 The block SHALL have parameter NumIn, default 4, meaning the number of requesters observed (power of 2, 2..64).
REQ-002 The block SHALL have parameter PrioWidth, default 4, meaning the width of the priority output fed to arbiter rr inputs (must be >= $clog2(NumIn)).
REQ-003 The block SHALL have parameter StarveThresh, default 15, meaning the consecutive-wait cycles that mark a requester as starved (1..255).
REQ-004 The block SHALL have parameter LfsrSeed, default 16'h0001, meaning the nonzero LFSR reset value.
REQ-005 The block SHALL have port clk_i  input  1  the single clock.
REQ-006 The block SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have port req_i  input  NumIn  requests of the arbitrated network inputs.
REQ-008 The block SHALL have port gnt_i  input  NumIn  grants returned to those inputs.
REQ-009 The block SHALL have port adv_i  input  1  advance enable (any downstream handshake completed).
REQ-010 The block SHALL have port rr_o  output  PrioWidth  priority value for the arbiters.
REQ-011 The block SHALL have port lock_o  output  1  high while in LOCK state.
REQ-012 The block SHALL have port lock_idx_o  output  $clog2(NumIn)  index of the requester being protected.

Function
REQ-013 Per requester k, wait counter wcnt[k] (width $clog2(StarveThresh+1)) SHALL increment when req_i[k] & ~gnt_i[k], saturating at StarveThresh, and SHALL clear to 0 when gnt_i[k] or ~req_i[k].
REQ-014 starved[k] SHALL be wcnt[k] == StarveThresh (registered counter value, no combinational path from req_i/gnt_i).
REQ-015 The LFSR SHALL be 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), shifting right once per cycle in which adv_i=1 and state is RAND.
REQ-016 FSM states SHALL be RAND and LOCK.
REQ-017 In RAND, rr_o SHALL equal lfsr[PrioWidth-1:0], lock_o=0, lock_idx_o=0.
REQ-018 RAND->LOCK SHALL occur on the clock edge after any starved[k]=1; lock_idx_o SHALL register the lowest starved index.
REQ-019 In LOCK, rr_o SHALL equal lock_idx_o zero-extended to PrioWidth, lock_o=1, and the LFSR SHALL hold.
REQ-020 LOCK->RAND SHALL occur on the edge where gnt_i[lock_idx_o]=1 or req_i[lock_idx_o]=0; other starved requesters SHALL not preempt the lock.
REQ-021 If after returning to RAND another counter is still starved, the FSM SHALL re-enter LOCK on the next edge (one RAND cycle minimum between locks).
REQ-022 Counters SHALL keep updating in both states; simultaneous increment and clear conditions cannot occur (REQ-013 is exclusive).
REQ-023 All outputs SHALL be registered or decoded from registered state only; latency from starvation to lock_o is 1 cycle.

Reset
REQ-024 On rst_i=1, asynchronously: state=RAND, lfsr=LfsrSeed, all wcnt=0, lock_idx=0; hence rr_o=LfsrSeed[PrioWidth-1:0], lock_o=0, lock_idx_o=0.
REQ-025 Reset asserted mid-LOCK SHALL drop lock_o immediately (same cycle, no clock needed).

Configuration
REQ-026 Macro TCDM_PRIO_CTRL_STATS_EN: when defined, the block SHALL add output lock_cnt_o (16 bits), counting RAND->LOCK transitions, wrapping at 16'hFFFF->0, reset to 0; when undefined, the port and counter SHALL not exist and behaviour is otherwise identical.

Verification
REQ-027 Reset, adv_i=1 for 3 cycles, no requests -> rr_o sequence 4'h1, 4'h0 (lfsr 16'hB400), 4'h0 (16'h5A00), 4'h0 (16'h2D00); lock_o stays 0.
REQ-028 NumIn=4, StarveThresh=15: req_i[2]=1, gnt_i[2]=0 held -> lock_o=1, lock_idx_o=2, rr_o=4'h2 in cycle 16 after req asserted; LFSR frozen.
REQ-029 In LOCK on idx 2, pulse gnt_i[2]=1 -> next cycle lock_o=0, rr_o resumes from frozen LFSR value.
REQ-030 Requesters 1 and 3 starve the same cycle -> lock_idx_o=1; after gnt_i[1], one RAND cycle, then LOCK with lock_idx_o=3.
REQ-031 rst_i asserted asynchronously during LOCK -> lock_o=0, rr_o=LfsrSeed[3:0] before next clock edge; counters 0.
REQ-032 With TCDM_PRIO_CTRL_STATS_EN, three lock episodes -> lock_cnt_o=3; preload to 16'hFFFF then one lock -> 0.
